// File: rtl/cand_sched_pkg.sv
// Shared types and width helpers for the CAND gated-clock enable scheduler.
package cand_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EN_WAIT,
    DIS_WAIT
  } sched_state_t;

  localparam int NUM_DOM_DFLT = 4;
  localparam int STAGGER_DFLT = 8;
  localparam int CNT_W_DFLT   = $clog2(STAGGER_DFLT);
  localparam int PTR_W_DFLT   = $clog2(NUM_DOM_DFLT);

  function automatic int cnt_w(input int stagger);
    return ($clog2(stagger) < 1) ? 1 : $clog2(stagger);
  endfunction

  function automatic int ptr_w(input int num_dom);
    return ($clog2(num_dom) < 1) ? 1 : $clog2(num_dom);
  endfunction

endpackage

// File: rtl/cand_rr_pick.sv
// Combinational first-set finder starting at ptr and wrapping past N-1 to 0.
module cand_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  vec,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  // Walk from the far end so the closest hit to ptr is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[(int'(ptr) + i) % N]) begin
        idx   = PW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cand_enable_scheduler.sv
// Staggered SEN sequencer for NUM_DOM CAND buffers: round-robin enables, idle-timeout gating.
// States: IDLE picks next enable/disable, EN_WAIT holds stagger after SEN rise, DIS_WAIT drops SEN then holds.
module cand_enable_scheduler
  import cand_sched_pkg::*;
#(
  parameter int NUM_DOM = NUM_DOM_DFLT,
  parameter int STAGGER = STAGGER_DFLT,
  parameter int ACK_DLY = 2,
  parameter int IDLE_W  = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NUM_DOM-1:0] REQ,
  input  logic               FORCE_ON,
  input  logic [IDLE_W-1:0]  IDLE_TIMEOUT,
  output logic [NUM_DOM-1:0] SEN,
  output logic [NUM_DOM-1:0] ACK,
  output logic               BUSY
);

  localparam int CNT_W = cnt_w(STAGGER);
  localparam int PTR_W = ptr_w(NUM_DOM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] ACK_AT   = CNT_W'(ACK_DLY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DOM - 1);
  // ACK_DLY == STAGGER lands one edge after EN_WAIT ends, so it is issued from IDLE.
  localparam bit ACK_LATE = (ACK_DLY >= STAGGER);

  sched_state_t       state, state_nxt;
  logic [NUM_DOM-1:0] ereq, en_elig, dis_elig, sen_nxt, ack_nxt;
  logic [IDLE_W-1:0]  idle_cnt [NUM_DOM];
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, cur, cur_nxt, en_idx, dis_idx;
  logic               en_vld, dis_vld;
  logic               ack_late, ack_late_nxt, req_held, req_held_nxt;

  assign ereq    = REQ | {NUM_DOM{FORCE_ON}};
  assign en_elig = ereq & ~SEN;

  always_comb begin
    dis_elig = '0;
    for (int i = 0; i < NUM_DOM; i++)
      dis_elig[i] = SEN[i] & ~ereq[i] & (idle_cnt[i] >= IDLE_TIMEOUT);
  end

  cand_rr_pick #(.N(NUM_DOM), .PW(PTR_W)) u_en_pick (
    .vec   (en_elig),
    .ptr   (rr_ptr),
    .idx   (en_idx),
    .valid (en_vld)
  );

  cand_rr_pick #(.N(NUM_DOM), .PW(PTR_W)) u_dis_pick (
    .vec   (dis_elig),
    .ptr   ('0),
    .idx   (dis_idx),
    .valid (dis_vld)
  );

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_DOM; i++) begin
      if (!RSTN || ereq[i] || !SEN[i])
        idle_cnt[i] <= '0;
      else if (idle_cnt[i] != '1)
        idle_cnt[i] <= idle_cnt[i] + IDLE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      SEN      <= '0;
      ACK      <= '0;
      cnt      <= '0;
      rr_ptr   <= '0;
      cur      <= '0;
      ack_late <= 1'b0;
      req_held <= 1'b0;
    end else begin
      state    <= state_nxt;
      SEN      <= sen_nxt;
      ACK      <= ack_nxt;
      cnt      <= cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      cur      <= cur_nxt;
      ack_late <= ack_late_nxt;
      req_held <= req_held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (en_vld) state_nxt = EN_WAIT;
                else if (dis_vld) state_nxt = DIS_WAIT;
      EN_WAIT:  if (cnt == CNT_LAST) state_nxt = IDLE;
      DIS_WAIT: if (!SEN[cur] && cnt == CNT_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sen_nxt      = SEN;
    ack_nxt      = ACK;
    cnt_nxt      = cnt;
    rr_ptr_nxt   = rr_ptr;
    cur_nxt      = cur;
    ack_late_nxt = 1'b0;
    req_held_nxt = req_held & ereq[cur];
    BUSY         = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (ack_late && req_held && ereq[cur]) ack_nxt[cur] = 1'b1;
        if (en_vld) begin
          sen_nxt[en_idx] = 1'b1;
          cur_nxt         = en_idx;
          rr_ptr_nxt      = (en_idx == PTR_LAST) ? '0 : en_idx + PTR_W'(1);
          cnt_nxt         = CNT_W'(1);
          req_held_nxt    = 1'b1;
        end else if (dis_vld) begin
          ack_nxt[dis_idx] = 1'b0;
          cur_nxt          = dis_idx;
          cnt_nxt          = CNT_W'(1);
        end
      end
      EN_WAIT: begin
        // A request that lapsed at any point before its ACK edge never gets ACK.
        if (!ACK_LATE && cnt == ACK_AT && req_held && ereq[cur]) ack_nxt[cur] = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_nxt      = '0;
          ack_late_nxt = ACK_LATE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DIS_WAIT: begin
        if (SEN[cur]) sen_nxt[cur] = 1'b0;
        else if (cnt == CNT_LAST) cnt_nxt = '0;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cand_enable_scheduler.sv
// Directed plus randomized bench against a timeline model of the enable scheduler.
module tb_cand_enable_scheduler;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int AD = 2;
  localparam int IW = 8;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic [N-1:0]  REQ;
  logic          FORCE_ON;
  logic [IW-1:0] IDLE_TIMEOUT;
  logic [N-1:0]  SEN, ACK;
  logic          BUSY;

  int checks   = 0;
  int failures = 0;

  // Model: outputs plus a timeline (cycle from which the scheduler is free again).
  logic [N-1:0] m_sen, m_ack;
  int  m_idle [N];
  int  m_rr, cyc, idle_from;
  int  ack_dom, ack_edge, off_dom, off_edge;
  bit  ack_ok, m_rst;
  int  last_chg;
  logic [N-1:0] prev_sen;

  always #5 CLK = ~CLK;

  cand_enable_scheduler #(.NUM_DOM(N), .STAGGER(S), .ACK_DLY(AD), .IDLE_W(IW)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .REQ          (REQ),
    .FORCE_ON     (FORCE_ON),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .SEN          (SEN),
    .ACK          (ACK),
    .BUSY         (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    int e, k, j, tmo;
    logic [N-1:0] er, enl, dis;
    e = cyc + 1;
    m_rst = !RSTN;
    if (!RSTN) begin
      m_sen = '0; m_ack = '0; m_rr = 0;
      for (int i = 0; i < N; i++) m_idle[i] = 0;
      ack_dom = -1; off_dom = -1; idle_from = e; cyc = e;
      return;
    end
    er  = REQ | {N{FORCE_ON}};
    tmo = int'(IDLE_TIMEOUT);
    enl = er & ~m_sen;
    dis = '0;
    for (int i = 0; i < N; i++) dis[i] = m_sen[i] && !er[i] && (m_idle[i] >= tmo);
    k = -1;
    for (int o = 0; o < N; o++) if (k < 0 && enl[(m_rr + o) % N]) k = (m_rr + o) % N;
    j = -1;
    for (int i = 0; i < N; i++) if (j < 0 && dis[i]) j = i;
    for (int i = 0; i < N; i++) begin
      if (er[i] || !m_sen[i]) m_idle[i] = 0;
      else if (m_idle[i] < 2**IW - 1) m_idle[i]++;
    end
    if (ack_dom >= 0) begin
      if (!er[ack_dom]) ack_ok = 0;
      if (e == ack_edge) begin
        if (ack_ok) m_ack[ack_dom] = 1'b1;
        ack_dom = -1;
      end
    end
    if (off_dom >= 0 && e == off_edge) begin
      m_sen[off_dom] = 1'b0;
      off_dom = -1;
    end
    if (cyc >= idle_from) begin
      if (k >= 0) begin
        m_sen[k] = 1'b1;
        m_rr = (k + 1) % N;
        ack_dom = k; ack_edge = e + AD; ack_ok = 1;
        idle_from = e + S - 1;
      end else if (j >= 0) begin
        m_ack[j] = 1'b0;
        off_dom = j; off_edge = e + 1;
        idle_from = e + S;
      end
    end
    cyc = e;
  endtask

  task automatic check_outputs();
    chk("sen", 32'(SEN), 32'(m_sen));
    chk("ack", 32'(ACK), 32'(m_ack));
    chk("busy", 32'(BUSY), 32'(cyc < idle_from));
    chk("ack_implies_sen", 32'(ACK & ~SEN), 32'h0);
    if (m_rst) begin
      prev_sen = SEN;
      last_chg = -1000;
    end else if (SEN !== prev_sen) begin
      chk("stagger_gap", 32'((cyc - last_chg) >= S), 32'h1);
      last_chg = cyc;
      prev_sen = SEN;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    int b;
    RSTN = 1'b0; REQ = 4'b1111; FORCE_ON = 1'b0; IDLE_TIMEOUT = 8'd5;
    m_sen = '0; m_ack = '0; m_rr = 0; cyc = 0; idle_from = 0;
    ack_dom = -1; off_dom = -1; ack_ok = 0; m_rst = 0;
    for (int i = 0; i < N; i++) m_idle[i] = 0;
    last_chg = -1000; prev_sen = '0;

    repeat (3) begin
      step();
      chk("rst_sen", 32'(SEN), 32'h0);
      chk("rst_ack", 32'(ACK), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
    end
    RSTN = 1'b1;

    // Round-robin stagger from pointer 0.
    step();          chk("rr_sen0", 32'(SEN), 32'b0001);
    repeat (8) step(); chk("rr_sen1", 32'(SEN), 32'b0011);
    repeat (8) step(); chk("rr_sen2", 32'(SEN), 32'b0111);
    repeat (8) step(); chk("rr_sen3", 32'(SEN), 32'b1111);
    repeat (2) step(); chk("rr_ack_all", 32'(ACK), 32'b1111);
    repeat (10) step();

    // Idle gating with timeout 5.
    REQ = 4'b1101;
    repeat (5) step(); chk("idle_ack_hold", 32'(ACK), 32'b1111);
    step();            chk("idle_ack_fall", 32'(ACK), 32'b1101);
                       chk("idle_sen_hold", 32'(SEN), 32'b1111);
    step();            chk("idle_sen_fall", 32'(SEN), 32'b1101);
    repeat (12) step();

    REQ = 4'b1111;
    step();            chk("reenable_sen", 32'(SEN), 32'b1111);
    repeat (10) step(); chk("reenable_ack", 32'(ACK), 32'b1111);

    // Request pulse restarts the timeout.
    REQ = 4'b1101; repeat (3) step();
    REQ = 4'b1111; step();
    REQ = 4'b1101;
    repeat (5) step(); chk("restart_ack_hold", 32'(ACK), 32'b1111);
    step();            chk("restart_ack_fall", 32'(ACK), 32'b1101);
    repeat (12) step();

    // Enable wins over a simultaneous disable.
    REQ = 4'b0111; repeat (30) step();
    chk("prio_setup_sen", 32'(SEN), 32'b0111);
    chk("prio_setup_ack", 32'(ACK), 32'b0111);
    REQ = 4'b0110; repeat (5) step();
    REQ = 4'b1110; step();
    chk("prio_sen3_first", 32'(SEN), 32'b1111);
    chk("prio_ack0_kept", 32'(ACK[0]), 32'h1);
    repeat (7) step(); chk("prio_ack_hold", 32'(ACK), 32'b1111);
    step();            chk("prio_ack0_fall", 32'(ACK), 32'b1110);
    step();            chk("prio_sen0_fall", 32'(SEN), 32'b1110);
    repeat (12) step();

    // FORCE_ON, then release with zero timeout: lowest-first gating.
    FORCE_ON = 1'b1; REQ = 4'b0000;
    repeat (50) step();
    chk("force_sen", 32'(SEN), 32'b1111);
    chk("force_ack", 32'(ACK), 32'b1111);
    IDLE_TIMEOUT = 8'd0; FORCE_ON = 1'b0;
    repeat (2) step(); chk("gate0", 32'(SEN), 32'b1110);
    repeat (9) step(); chk("gate1", 32'(SEN), 32'b1100);
    repeat (9) step(); chk("gate2", 32'(SEN), 32'b1000);
    repeat (9) step(); chk("gate3", 32'(SEN), 32'b0000);
    repeat (10) step();

    // Reset mid-sequence drops everything at once.
    REQ = 4'b1111; repeat (11) step();
    RSTN = 1'b0; step();
    chk("midrst_sen", 32'(SEN), 32'h0);
    chk("midrst_ack", 32'(ACK), 32'h0);
    chk("midrst_busy", 32'(BUSY), 32'h0);
    RSTN = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, N - 1);
        REQ[b] = ~REQ[b];
      end
      if ($urandom_range(0, 199) == 0) FORCE_ON = ~FORCE_ON;
      if ($urandom_range(0, 299) == 0) IDLE_TIMEOUT = 8'($urandom_range(0, 12));
      RSTN = ($urandom_range(0, 799) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
